// File: rtl/cache_traffic_gen_if.sv
// Valid/ready request channel plus single-beat response between the traffic
// generator (master) and the cache under test (slave).
interface cache_traffic_gen_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/cache_traffic_gen.sv
// Address-sweep request sequencer and read-data checker standing in for the CPU
// above one cache level; one request outstanding, status held until next start.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | req_valid high, waiting for req_ready
// WAIT  | request accepted, waiting for resp_valid or timeout
// FIN   | done pulse cycle, then back to IDLE
module cache_traffic_gen #(
  parameter int                ADDR_W    = 64,
  parameter int                DATA_W    = 64,
  parameter int                CNT_W     = 16,
  parameter logic [DATA_W-1:0] DATA_SEED = DATA_W'(8),
  parameter int                MAX_WAIT  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [1:0]          i_mode,
  input  logic [ADDR_W-1:0]   i_base_addr,
  input  logic [ADDR_W-1:0]   i_stride,
  input  logic [CNT_W-1:0]    i_count,
  cache_traffic_gen_if.master bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [15:0]         o_err_count,
  output logic [ADDR_W-1:0]   o_first_err_addr,
  output logic                o_timeout
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [1:0] MODE_WR  = 2'd0;
  localparam logic [1:0] MODE_RD  = 2'd1;
  localparam logic [1:0] MODE_SEQ = 2'd2;
  localparam logic [1:0] MODE_ILV = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;
  state_t r_state, w_state_nxt;

  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_base, r_stride, r_addr;
  logic [CNT_W-1:0]  r_count, r_idx;
  logic              r_phase;
  logic [WAIT_W-1:0] r_wait;
  logic              r_req_valid, r_req_write;
  logic [DATA_W-1:0] r_req_wdata;
  logic              r_busy, r_done, r_pass, r_timeout;
  logic [15:0]       r_err_count;
  logic [ADDR_W-1:0] r_first_err_addr;

  logic              w_launch, w_hs, w_resp, w_tmo;
  logic              w_last, w_idx_last, w_nxt_phase, w_nxt_write, w_mismatch;
  logic [CNT_W-1:0]  w_nxt_idx;
  logic [ADDR_W-1:0] w_nxt_addr;

  assign w_idx_last = (r_idx == r_count - CNT_W'(1));
  // r_req_wdata always holds DATA_SEED + index, so it doubles as the read expectation.
  assign w_mismatch = !r_req_write && (bus.resp_data != r_req_wdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_hs        = 1'b0;
    w_resp      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE:
        if (i_start) begin
          w_launch    = 1'b1;
          w_state_nxt = (i_count == '0) ? S_FIN : S_ISSUE;
        end
      S_ISSUE:
        if (r_req_valid && bus.req_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = S_WAIT;
        end
      S_WAIT:
        if (bus.resp_valid) begin
          w_resp      = 1'b1;
          w_state_nxt = w_last ? S_FIN : S_ISSUE;
        end else if (r_wait == '0) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_FIN;
        end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_nxt_idx   = r_idx + CNT_W'(1);
    w_nxt_addr  = r_addr + r_stride;
    w_nxt_phase = r_phase;
    w_last      = 1'b0;
    case (r_mode)
      MODE_SEQ:
        if (w_idx_last) begin
          if (!r_phase) begin
            w_nxt_idx   = '0;
            w_nxt_addr  = r_base;
            w_nxt_phase = 1'b1;
          end else begin
            w_last = 1'b1;
          end
        end
      MODE_ILV:
        if (!r_phase) begin
          w_nxt_idx   = r_idx;
          w_nxt_addr  = r_addr;
          w_nxt_phase = 1'b1;
        end else begin
          w_nxt_phase = 1'b0;
          w_last      = w_idx_last;
        end
      default: w_last = w_idx_last;
    endcase
    case (r_mode)
      MODE_WR: w_nxt_write = 1'b1;
      MODE_RD: w_nxt_write = 1'b0;
      default: w_nxt_write = !w_nxt_phase;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode           <= MODE_WR;
      r_base           <= '0;
      r_stride         <= '0;
      r_addr           <= '0;
      r_count          <= '0;
      r_idx            <= '0;
      r_phase          <= 1'b0;
      r_wait           <= '0;
      r_req_valid      <= 1'b0;
      r_req_write      <= 1'b0;
      r_req_wdata      <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_timeout        <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_launch) begin
        r_mode           <= i_mode;
        r_base           <= i_base_addr;
        r_stride         <= i_stride;
        r_count          <= i_count;
        r_idx            <= '0;
        r_phase          <= 1'b0;
        r_addr           <= i_base_addr;
        r_req_write      <= (i_mode != MODE_RD);
        r_req_wdata      <= DATA_SEED;
        r_err_count      <= '0;
        r_first_err_addr <= '0;
        r_timeout        <= 1'b0;
        if (i_count == '0) begin
          r_done <= 1'b1;
          r_pass <= 1'b1;
          r_busy <= 1'b0;
        end else begin
          r_req_valid <= 1'b1;
          r_busy      <= 1'b1;
          r_pass      <= 1'b0;
        end
      end
      if (w_hs) begin
        r_req_valid <= 1'b0;
        r_wait      <= WAIT_W'(MAX_WAIT - 1);
      end else if (r_state == S_WAIT && r_wait != '0) begin
        r_wait <= r_wait - WAIT_W'(1);
      end
      if (w_resp) begin
        if (w_mismatch) begin
          if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
          if (r_err_count == '0)       r_first_err_addr <= r_addr;
        end
        if (w_last) begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_pass <= (r_err_count == '0) && !w_mismatch;
        end else begin
          r_idx       <= w_nxt_idx;
          r_addr      <= w_nxt_addr;
          r_phase     <= w_nxt_phase;
          r_req_write <= w_nxt_write;
          r_req_wdata <= DATA_SEED + DATA_W'(w_nxt_idx);
          r_req_valid <= 1'b1;
        end
      end
      if (w_tmo) begin
        r_timeout <= 1'b1;
        if (r_err_count == '0) r_first_err_addr <= r_addr;
        r_done <= 1'b1;
        r_busy <= 1'b0;
        r_pass <= 1'b0;
      end
    end
  end

  assign bus.req_valid     = r_req_valid;
  assign bus.req_write     = r_req_write;
  assign bus.req_addr      = r_addr;
  assign bus.req_wdata     = r_req_wdata;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_pass            = r_pass;
  assign o_err_count       = r_err_count;
  assign o_first_err_addr  = r_first_err_addr;
  assign o_timeout         = r_timeout;
endmodule

// File: tb/tb_cache_traffic_gen.sv
// Bench for cache_traffic_gen: table of directed sweeps, random sweeps checked
// against an index-arithmetic model, plus hand sequences for timeout/reset/count 0.
module tb_cache_traffic_gen;
  localparam int          AW   = 64;
  localparam int          DW   = 64;
  localparam int          MW   = 64;
  localparam logic [63:0] SEED = 64'd8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start;
  logic [1:0]  i_mode;
  logic [63:0] i_base_addr, i_stride;
  logic [15:0] i_count;
  logic        o_busy, o_done, o_pass, o_timeout;
  logic [15:0] o_err_count;
  logic [63:0] o_first_err_addr;

  always #5 clk = ~clk;

  cache_traffic_gen_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cache_traffic_gen #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16), .DATA_SEED(SEED), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_base_addr(i_base_addr), .i_stride(i_stride), .i_count(i_count), .bus(bus),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_err_count(o_err_count),
    .o_first_err_addr(o_first_err_addr), .o_timeout(o_timeout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
  } op_t;

  op_t         obs_q[$];
  op_t         exp_q[$];
  logic [63:0] ret_q[$];
  logic [63:0] mem [logic [63:0]];

  int          cfg_stall = 0;
  int          cfg_dly = 0;
  bit          cfg_noresp = 1'b0;
  logic [31:0] cfg_bad = '0;
  int          rd_cnt = 0;
  int          stall_viol = 0;
  int          hs_cyc = 0;
  int          last_resp_cyc = 0;

  // Cache stand-in: optional ready stall, optional response delay, memory-backed reads,
  // and per-read-ordinal corruption selected by cfg_bad.
  initial begin : responder
    op_t         op;
    logic [63:0] rd;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    @(negedge clk);
    forever begin
      if (bus.req_valid !== 1'b1) begin
        @(negedge clk);
      end else begin
        op.w = bus.req_write;
        op.a = bus.req_addr;
        op.d = bus.req_wdata;
        for (int k = 0; k < cfg_stall; k++) begin
          @(negedge clk);
          if (bus.req_valid !== 1'b1 || bus.req_write !== op.w ||
              bus.req_addr !== op.a || bus.req_wdata !== op.d) stall_viol++;
        end
        bus.req_ready = 1'b1;
        hs_cyc = cyc;
        @(negedge clk);
        bus.req_ready = 1'b0;
        obs_q.push_back(op);
        if (!cfg_noresp) begin
          repeat (cfg_dly) @(negedge clk);
          if (op.w) begin
            mem[op.a] = op.d;
            rd = ~op.d;
          end else begin
            rd = mem.exists(op.a) ? mem[op.a] : 64'hBAD0_BAD0_BAD0_BAD0;
            if (rd_cnt < 32 && cfg_bad[rd_cnt]) rd = rd ^ 64'h1;
            rd_cnt++;
            ret_q.push_back(rd);
          end
          bus.resp_valid = 1'b1;
          bus.resp_data  = rd;
          last_resp_cyc  = cyc;
          @(negedge clk);
          bus.resp_valid = 1'b0;
        end
      end
    end
  end

  task automatic push_op(input logic w, input logic [63:0] b, input logic [63:0] s, input int i);
    op_t op;
    op.w = w;
    op.a = b + 64'(i) * s;
    op.d = SEED + 64'(i);
    exp_q.push_back(op);
  endtask

  task automatic build_model(input logic [1:0] m, input logic [63:0] b, input logic [63:0] s, input int n);
    exp_q.delete();
    case (m)
      2'd0: for (int i = 0; i < n; i++) push_op(1'b1, b, s, i);
      2'd1: for (int i = 0; i < n; i++) push_op(1'b0, b, s, i);
      2'd2: begin
        for (int i = 0; i < n; i++) push_op(1'b1, b, s, i);
        for (int i = 0; i < n; i++) push_op(1'b0, b, s, i);
      end
      default: for (int i = 0; i < n; i++) begin
        push_op(1'b1, b, s, i);
        push_op(1'b0, b, s, i);
      end
    endcase
  endtask

  task automatic model_eval(input string tag, output int e_err, output logic [63:0] e_first);
    int bad, rd, nmin;
    bad = 0; rd = 0; e_err = 0; e_first = '0;
    chk({tag, " n_ops"}, 64'(obs_q.size()), 64'(exp_q.size()));
    nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < nmin; k++) begin
      if (obs_q[k].w !== exp_q[k].w || obs_q[k].a !== exp_q[k].a ||
          (exp_q[k].w && obs_q[k].d !== exp_q[k].d)) begin
        if (bad == 0)
          $display("  %s op %0d: got w=%0b a=%0h d=%0h, want w=%0b a=%0h d=%0h", tag, k,
                   obs_q[k].w, obs_q[k].a, obs_q[k].d, exp_q[k].w, exp_q[k].a, exp_q[k].d);
        bad++;
      end
    end
    chk({tag, " op_seq_bad"}, 64'(bad), 64'd0);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (!exp_q[k].w) begin
        if (rd < ret_q.size() && ret_q[rd] !== exp_q[k].d) begin
          if (e_err == 0) e_first = exp_q[k].a;
          e_err++;
        end
        rd++;
      end
    end
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge where done is seen.
  task automatic run_one(input string tag, input logic [1:0] m, input logic [63:0] b,
                         input logic [63:0] s, input logic [15:0] n, input bit poke);
    int guard;
    obs_q.delete(); ret_q.delete(); mem.delete();
    rd_cnt = 0; stall_viol = 0;
    if (m == 2'd1) for (int i = 0; i < int'(n); i++) mem[b + 64'(i) * s] = SEED + 64'(i);
    build_model(m, b, s, int'(n));
    i_start = 1'b1; i_mode = m; i_base_addr = b; i_stride = s; i_count = n;
    @(negedge clk);
    i_start = 1'b0; i_mode = ~m; i_base_addr = {$urandom, $urandom};
    i_stride = {$urandom, $urandom}; i_count = 16'($urandom);
    chk({tag, " busy_T1"}, 64'(o_busy), 64'd1);
    chk({tag, " valid_T1"}, 64'(bus.req_valid), 64'd1);
    guard = 0;
    while (o_done !== 1'b1 && guard < 5000) begin
      i_start = (poke && guard == 3);
      @(negedge clk);
      guard++;
    end
    i_start = 1'b0;
    chk({tag, " done_seen"}, 64'(o_done), 64'd1);
    chk({tag, " busy_at_done"}, 64'(o_busy), 64'd0);
    if (!cfg_noresp) chk({tag, " done_lat"}, 64'(cyc - last_resp_cyc), 64'd1);
  endtask

  task automatic after_done(input string tag, input logic exp_pass);
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(o_done), 64'd0);
    chk({tag, " pass_held"}, 64'(o_pass), 64'(exp_pass));
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [63:0] b;
    logic [63:0] s;
    logic [15:0] n;
    int          stall;
    int          dly;
    logic [31:0] bad;
    bit          poke;
    logic [15:0] e_err;
    logic [63:0] e_first;
    logic        e_pass;
  } vec_t;

  vec_t vec [7];

  initial begin : main
    int          e_err;
    logic [63:0] e_first;
    string       tag;
    logic [1:0]  m;
    logic [63:0] b, s;
    logic [15:0] n;

    vec[0] = '{2'd0, 64'd4096, 64'd4096, 16'd8, 0, 0, 32'h0,  1'b1, 16'd0, 64'd0,     1'b1};
    vec[1] = '{2'd2, 64'd0,    64'd64,   16'd4, 0, 1, 32'h0,  1'b0, 16'd0, 64'd0,     1'b1};
    vec[2] = '{2'd1, 64'd4096, 64'd4096, 16'd8, 0, 0, 32'h28, 1'b0, 16'd2, 64'd16384, 1'b0};
    vec[3] = '{2'd3, 64'h2000, 64'd8,    16'd2, 5, 0, 32'h0,  1'b0, 16'd0, 64'd0,     1'b1};
    vec[4] = '{2'd3, 64'h40,   64'h10,   16'd3, 1, 2, 32'h2,  1'b0, 16'd1, 64'h50,    1'b0};
    vec[5] = '{2'd2, 64'h80,   64'd0,    16'd3, 0, 0, 32'h0,  1'b0, 16'd2, 64'h80,    1'b0};
    vec[6] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFF0, 64'd8, 16'd4, 2, 0, 32'h0, 1'b0, 16'd0, 64'd0, 1'b1};

    i_start = 1'b0; i_mode = '0; i_base_addr = '0; i_stride = '0; i_count = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(o_busy), 64'd0);
    chk("rst req_valid", 64'(bus.req_valid), 64'd0);
    chk("rst pass", 64'(o_pass), 64'd0);
    chk("rst err_count", 64'(o_err_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 7; t++) begin
      tag = $sformatf("vec%0d", t);
      cfg_stall = vec[t].stall; cfg_dly = vec[t].dly; cfg_bad = vec[t].bad; cfg_noresp = 1'b0;
      run_one(tag, vec[t].m, vec[t].b, vec[t].s, vec[t].n, vec[t].poke);
      model_eval(tag, e_err, e_first);
      chk({tag, " err_count"}, 64'(o_err_count), 64'(vec[t].e_err));
      chk({tag, " first_err_addr"}, o_first_err_addr, vec[t].e_first);
      chk({tag, " pass"}, 64'(o_pass), 64'(vec[t].e_pass));
      chk({tag, " timeout"}, 64'(o_timeout), 64'd0);
      chk({tag, " model_err"}, 64'(o_err_count), 64'(e_err));
      chk({tag, " stall_stable"}, 64'(stall_viol), 64'd0);
      after_done(tag, vec[t].e_pass);
    end

    // Response never arrives after the first handshake.
    cfg_stall = 0; cfg_dly = 0; cfg_bad = '0; cfg_noresp = 1'b1;
    run_one("tmo", 2'd1, 64'h7000, 64'h100, 16'd4, 1'b0);
    chk("tmo timeout", 64'(o_timeout), 64'd1);
    chk("tmo pass", 64'(o_pass), 64'd0);
    chk("tmo first_err_addr", o_first_err_addr, 64'h7000);
    chk("tmo err_count", 64'(o_err_count), 64'd0);
    chk("tmo latency", 64'(cyc - hs_cyc), 64'(MW + 1));
    chk("tmo n_ops", 64'(obs_q.size()), 64'd1);
    after_done("tmo", 1'b0);

    // count == 0: done and pass the cycle after start, nothing issued.
    cfg_noresp = 1'b0;
    obs_q.delete();
    i_start = 1'b1; i_mode = 2'd2; i_base_addr = 64'h1234; i_stride = 64'd4; i_count = 16'd0;
    @(negedge clk);
    i_start = 1'b0;
    chk("cnt0 done_T1", 64'(o_done), 64'd1);
    chk("cnt0 pass", 64'(o_pass), 64'd1);
    chk("cnt0 req_valid", 64'(bus.req_valid), 64'd0);
    @(negedge clk);
    chk("cnt0 done_pulse", 64'(o_done), 64'd0);
    repeat (3) @(negedge clk);
    chk("cnt0 no_requests", 64'(obs_q.size()), 64'd0);

    // Reset in the middle of a run, then a normal run.
    cfg_noresp = 1'b1;
    i_start = 1'b1; i_mode = 2'd0; i_base_addr = 64'h9000; i_stride = 64'd4; i_count = 16'd5;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst req_valid", 64'(bus.req_valid), 64'd0);
    chk("mid_rst req_write", 64'(bus.req_write), 64'd0);
    chk("mid_rst req_addr", bus.req_addr, 64'd0);
    chk("mid_rst req_wdata", bus.req_wdata, 64'd0);
    chk("mid_rst busy", 64'(o_busy), 64'd0);
    chk("mid_rst done", 64'(o_done), 64'd0);
    chk("mid_rst pass", 64'(o_pass), 64'd0);
    chk("mid_rst timeout", 64'(o_timeout), 64'd0);
    chk("mid_rst err_count", 64'(o_err_count), 64'd0);
    chk("mid_rst first_err_addr", o_first_err_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cfg_noresp = 1'b0;
    @(negedge clk);
    run_one("post_rst", 2'd3, 64'hA000, 64'h20, 16'd3, 1'b0);
    model_eval("post_rst", e_err, e_first);
    chk("post_rst pass", 64'(o_pass), 64'd1);
    after_done("post_rst", 1'b1);

    // Random sweeps against the model.
    for (int r = 0; r < 25; r++) begin
      tag = $sformatf("rnd%0d", r);
      m = 2'($urandom_range(0, 3));
      n = 16'($urandom_range(1, 6));
      b = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       s = 64'd0;
        1:       s = 64'd8;
        2:       s = {$urandom, $urandom};
        default: s = -64'd8;
      endcase
      cfg_stall = $urandom_range(0, 3);
      cfg_dly   = $urandom_range(0, 3);
      cfg_bad   = $urandom & $urandom & $urandom;
      run_one(tag, m, b, s, n, r[0]);
      model_eval(tag, e_err, e_first);
      chk({tag, " err_count"}, 64'(o_err_count), 64'(e_err));
      chk({tag, " first_err_addr"}, o_first_err_addr, e_first);
      chk({tag, " pass"}, 64'(o_pass), 64'(e_err == 0));
      chk({tag, " timeout"}, 64'(o_timeout), 64'd0);
      chk({tag, " stall_stable"}, 64'(stall_viol), 64'd0);
      after_done(tag, e_err == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule
